epp_regfile: RTL and testbench



---
 rtl/epp_pkg.sv | 22 ++
 rtl/epp_regfile_if.sv | 29 ++
 rtl/epp_sync.sv | 32 +++
 rtl/epp_regfile.sv | 171 +++++++++++++++++
 tb/tb_epp_regfile.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/epp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : epp_pkg
// Brief    : Shared widths, status bit positions and FSM state type for the
//            EPP register file.
// Revision : 1.0 - initial release
// ============================================================================
package epp_pkg;

    localparam int EPP_DW = 8;
    localparam int EPP_AW = 8;

    localparam int STAT_BUSY = 0;
    localparam int STAT_ERR  = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } epp_state_t;

endpackage
`default_nettype wire

// File: rtl/epp_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : epp_regfile_if
// Brief    : EPP handshake strobes and wait line; host is master, regfile is slave.
// Revision : 1.0 - initial release
// ============================================================================
interface epp_regfile_if;

    logic EppAstb;
    logic EppDstb;
    logic EppWR;
    logic EppWait;

    modport master (
        output EppAstb,
        output EppDstb,
        output EppWR,
        input  EppWait
    );

    modport slave (
        input  EppAstb,
        input  EppDstb,
        input  EppWR,
        output EppWait
    );

endinterface
`default_nettype wire

// File: rtl/epp_sync.sv
`default_nettype none
// ============================================================================
// Module   : epp_sync
// Brief    : Two-flop synchroniser; resets to all ones because strobes idle high.
// Revision : 1.0 - initial release
// ============================================================================
module epp_sync #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] i_async,
    output logic      [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule
`default_nettype wire

// File: rtl/epp_regfile.sv
`default_nettype none
// ============================================================================
// Module   : epp_regfile
// Brief    : Parametrised EPP slave register file with command strobes, status
//            register and optional address auto-increment.
// Revision : 1.0 - initial release
// ============================================================================
module epp_regfile
    import epp_pkg::*;
#(
    parameter int             NUM_REGS    = 16,
    parameter int             CMD_BASE    = 16,
    parameter int             NUM_CMDS    = 4,
    parameter logic [7:0]     STATUS_ADDR = 8'hFF,
    parameter int             AUTO_INC    = 1
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    epp_regfile_if.slave               epp,
    inout  wire  [EPP_DW-1:0]          EppDB,
    output logic [8*NUM_REGS-1:0]      regs_flat,
    output logic [NUM_CMDS-1:0]        cmd_pulse,
    output logic [EPP_DW-1:0]          cmd_arg,
    input  wire logic                  busy
);

    logic [2:0]          w_sync;
    logic                w_astb;
    logic                w_dstb;
    logic                w_wr;

    epp_state_t          r_state;
    epp_state_t          w_next;
    logic                w_start_addr;
    logic                w_start_data;
    logic                w_finish;

    logic [EPP_AW-1:0]   r_addr;
    logic [8*NUM_REGS-1:0] r_regs;
    logic                r_wait;
    logic                r_oe;
    logic [EPP_DW-1:0]   r_dout;
    logic [NUM_CMDS-1:0] r_pulse;
    logic [EPP_DW-1:0]   r_arg;
    logic                r_err;
    logic                r_dcyc;

    logic [NUM_CMDS-1:0] w_cmd_hit;
    logic                w_is_stat;
    logic [EPP_DW-1:0]   w_rd_data;

    epp_sync #(.WIDTH(3)) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async ({epp.EppAstb, epp.EppDstb, epp.EppWR}),
        .o_sync  (w_sync)
    );

    assign w_astb = w_sync[2];
    assign w_dstb = w_sync[1];
    assign w_wr   = w_sync[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Address strobe wins when both strobes are seen low together
    always_comb begin
        w_next       = r_state;
        w_start_addr = 1'b0;
        w_start_data = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_astb) begin
                    w_start_addr = 1'b1;
                    w_next       = ST_HOLD;
                end else if (!w_dstb) begin
                    w_start_data = 1'b1;
                    w_next       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_astb && w_dstb) begin
                    w_finish = 1'b1;
                    w_next   = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_hit = '0;
        for (int i = 0; i < NUM_CMDS; i++) begin
            if (int'(r_addr) == CMD_BASE + i) w_cmd_hit[i] = 1'b1;
        end
        w_is_stat = (r_addr == STATUS_ADDR);
        w_rd_data = '0;
        if (w_is_stat) begin
            w_rd_data[STAT_BUSY] = busy;
            w_rd_data[STAT_ERR]  = r_err;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(r_addr) == i) w_rd_data = r_regs[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= '0;
            r_regs  <= '0;
            r_wait  <= 1'b0;
            r_oe    <= 1'b0;
            r_dout  <= '0;
            r_pulse <= '0;
            r_arg   <= '0;
            r_err   <= 1'b0;
            r_dcyc  <= 1'b0;
        end else begin
            r_pulse <= '0;
            if (w_start_addr) begin
                r_wait <= 1'b1;
                r_dcyc <= 1'b0;
                if (w_wr) begin
                    r_oe   <= 1'b1;
                    r_dout <= r_addr;
                end else begin
                    r_addr <= EppDB;
                end
            end
            if (w_start_data) begin
                r_wait <= 1'b1;
                r_dcyc <= 1'b1;
                if (w_wr) begin
                    r_oe   <= 1'b1;
                    r_dout <= w_rd_data;
                    if (w_is_stat) r_err <= 1'b0;
                end else begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (int'(r_addr) == i) r_regs[8*i +: 8] <= EppDB;
                    end
                    // A command issued while the engine is busy is dropped and flagged
                    if (|w_cmd_hit) begin
                        if (!busy) begin
                            r_pulse <= w_cmd_hit;
                            r_arg   <= EppDB;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
            end
            if (w_finish) begin
                r_wait <= 1'b0;
                r_oe   <= 1'b0;
                if (AUTO_INC != 0 && r_dcyc) r_addr <= r_addr + 8'd1;
            end
        end
    end

    assign EppDB       = r_oe ? r_dout : {EPP_DW{1'bz}};
    assign epp.EppWait = r_wait;
    assign regs_flat   = r_regs;
    assign cmd_pulse   = r_pulse;
    assign cmd_arg     = r_arg;

endmodule
`default_nettype wire

// File: tb/tb_epp_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_epp_regfile
// Brief    : Directed self-checking bench for the EPP register file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_epp_regfile;

    logic        clk;
    logic        rst_n;
    logic        busy;
    logic        host_oe;
    logic [7:0]  host_data;
    wire  [7:0]  EppDB;
    logic [127:0] regs_flat;
    logic [3:0]  cmd_pulse;
    logic [7:0]  cmd_arg;

    int checks;
    int errors;
    int pulse_cnt;
    logic [3:0] last_pulse;

    epp_regfile_if epp_if ();

    epp_regfile #(
        .NUM_REGS    (16),
        .CMD_BASE    (16),
        .NUM_CMDS    (4),
        .STATUS_ADDR (8'hFF),
        .AUTO_INC    (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .epp       (epp_if),
        .EppDB     (EppDB),
        .regs_flat (regs_flat),
        .cmd_pulse (cmd_pulse),
        .cmd_arg   (cmd_arg),
        .busy      (busy)
    );

    // Released bus floats to 0xFF so a released DUT is observable
    assign EppDB = host_oe ? host_data : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (EppDB[g]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        pulse_cnt  = 0;
        last_pulse = '0;
    end

    always @(negedge clk) begin
        if (cmd_pulse != 4'b0000) begin
            pulse_cnt  = pulse_cnt + 1;
            last_pulse = cmd_pulse;
        end
    end

    task automatic do_cycle(input bit is_addr, input bit rd, input logic [7:0] wdata,
                            input int hold, output logic [7:0] rdata,
                            output logic [3:0] pulse_at_rise, output int rise_lat,
                            output int fall_lat);
        int n;
        @(negedge clk);
        epp_if.EppWR = rd;
        host_data    = wdata;
        host_oe      = !rd;
        #2;
        if (is_addr) epp_if.EppAstb = 1'b0;
        else         epp_if.EppDstb = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (epp_if.EppWait) break;
        end
        rise_lat      = n;
        rdata         = EppDB;
        pulse_at_rise = cmd_pulse;
        if (!epp_if.EppWait) begin
            checks++; errors++;
            $display("FAIL wait_rise_timeout got EppWait=%b expected 1", epp_if.EppWait);
        end
        repeat (hold) @(posedge clk);
        @(negedge clk); #2;
        epp_if.EppAstb = 1'b1;
        epp_if.EppDstb = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1; n++;
            if (!epp_if.EppWait) break;
        end
        fall_lat = n;
        if (epp_if.EppWait) begin
            checks++; errors++;
            $display("FAIL wait_fall_timeout got EppWait=%b expected 0", epp_if.EppWait);
        end
        host_oe = 1'b0;
    endtask

    task automatic addr_wr(input logic [7:0] a);
        logic [7:0] d; logic [3:0] p; int r, f;
        do_cycle(1'b1, 1'b0, a, 0, d, p, r, f);
    endtask

    task automatic data_wr(input logic [7:0] v);
        logic [7:0] d; logic [3:0] p; int r, f;
        do_cycle(1'b0, 1'b0, v, 0, d, p, r, f);
    endtask

    task automatic data_rd(output logic [7:0] v);
        logic [3:0] p; int r, f;
        do_cycle(1'b0, 1'b1, 8'h00, 0, v, p, r, f);
    endtask

    task automatic test_reset;
        checks++;
        if (epp_if.EppWait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b expected 0", epp_if.EppWait); end
        checks++;
        if (EppDB !== 8'hFF) begin errors++; $display("FAIL reset_bus got %h expected FF(released)", EppDB); end
        checks++;
        if (regs_flat !== '0) begin errors++; $display("FAIL reset_regs got %h expected 0", regs_flat); end
        checks++;
        if (cmd_pulse !== 4'b0000) begin errors++; $display("FAIL reset_pulse got %b expected 0000", cmd_pulse); end
        checks++;
        if (cmd_arg !== 8'h00) begin errors++; $display("FAIL reset_arg got %h expected 00", cmd_arg); end
    endtask

    task automatic test_write_latency;
        logic [7:0] d; logic [3:0] p; int r, f;
        addr_wr(8'h03);
        do_cycle(1'b0, 1'b0, 8'hA5, 0, d, p, r, f);
        checks++;
        if (r !== 3) begin errors++; $display("FAIL wr_rise_latency got %0d expected 3", r); end
        checks++;
        if (f !== 3) begin errors++; $display("FAIL wr_fall_latency got %0d expected 3", f); end
        checks++;
        if (regs_flat[31:24] !== 8'hA5) begin errors++; $display("FAIL wr_reg3 got %h expected A5", regs_flat[31:24]); end
    endtask

    task automatic test_auto_inc;
        logic [7:0] d; logic [3:0] p; int r, f;
        addr_wr(8'h00);
        data_wr(8'h11);
        data_wr(8'h22);
        data_wr(8'h33);
        checks++;
        if (regs_flat[23:0] !== 24'h332211) begin errors++; $display("FAIL inc_regs got %h expected 332211", regs_flat[23:0]); end
        do_cycle(1'b1, 1'b1, 8'h00, 0, d, p, r, f);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL inc_addr_read got %h expected 03", d); end
    endtask

    task automatic test_cmd;
        logic [7:0] d; logic [3:0] p; int r, f, c0;
        addr_wr(8'h11);
        c0 = pulse_cnt;
        do_cycle(1'b0, 1'b0, 8'h01, 20, d, p, r, f);
        repeat (3) @(posedge clk);
        checks++;
        if (p !== 4'b0010) begin errors++; $display("FAIL cmd_pulse_at_wait got %b expected 0010", p); end
        checks++;
        if (pulse_cnt - c0 !== 1) begin errors++; $display("FAIL cmd_pulse_count got %0d expected 1", pulse_cnt - c0); end
        checks++;
        if (last_pulse !== 4'b0010) begin errors++; $display("FAIL cmd_pulse_value got %b expected 0010", last_pulse); end
        checks++;
        if (cmd_arg !== 8'h01) begin errors++; $display("FAIL cmd_arg got %h expected 01", cmd_arg); end
    endtask

    task automatic test_cmd_busy;
        logic [7:0] d; int c0;
        busy = 1'b1;
        addr_wr(8'h12);
        c0 = pulse_cnt;
        data_wr(8'h77);
        repeat (3) @(posedge clk);
        checks++;
        if (pulse_cnt !== c0) begin errors++; $display("FAIL busy_no_pulse got %0d pulses expected 0", pulse_cnt - c0); end
        checks++;
        if (cmd_arg !== 8'h01) begin errors++; $display("FAIL busy_arg_kept got %h expected 01", cmd_arg); end
        addr_wr(8'hFF);
        data_rd(d);
        checks++;
        if (d !== 8'h03) begin errors++; $display("FAIL status_err_busy got %h expected 03", d); end
        busy = 1'b0;
        addr_wr(8'hFF);
        data_rd(d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL status_cleared got %h expected 00", d); end
    endtask

    task automatic test_read;
        logic [7:0] d; logic [3:0] p; int r, f;
        addr_wr(8'h02);
        data_wr(8'h5C);
        addr_wr(8'h02);
        do_cycle(1'b0, 1'b1, 8'h00, 2, d, p, r, f);
        checks++;
        if (d !== 8'h5C) begin errors++; $display("FAIL read_reg2 got %h expected 5C", d); end
        checks++;
        if (f > 3 || EppDB !== 8'hFF) begin errors++; $display("FAIL read_release got lat=%0d bus=%h expected <=3 FF", f, EppDB); end
        addr_wr(8'h40);
        data_rd(d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL read_unmapped got %h expected 00", d); end
        addr_wr(8'h10);
        data_rd(d);
        checks++;
        if (d !== 8'h00) begin errors++; $display("FAIL read_cmd_addr got %h expected 00", d); end
    endtask

    task automatic test_reset_mid;
        int n;
        addr_wr(8'h01);
        @(negedge clk);
        epp_if.EppWR = 1'b1;
        #2 epp_if.EppDstb = 1'b0;
        n = 0;
        while (n < 20 && !epp_if.EppWait) begin @(posedge clk); #1; n++; end
        checks++;
        if (EppDB !== 8'h22) begin errors++; $display("FAIL mid_read_data got %h expected 22", EppDB); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (epp_if.EppWait !== 1'b0) begin errors++; $display("FAIL mid_rst_wait got %b expected 0", epp_if.EppWait); end
        checks++;
        if (EppDB !== 8'hFF) begin errors++; $display("FAIL mid_rst_bus got %h expected FF(released)", EppDB); end
        checks++;
        if (regs_flat !== '0) begin errors++; $display("FAIL mid_rst_regs got %h expected 0", regs_flat); end
        epp_if.EppDstb = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        addr_wr(8'h06);
        data_wr(8'h4D);
        checks++;
        if (regs_flat[55:48] !== 8'h4D) begin errors++; $display("FAIL post_rst_write got %h expected 4D", regs_flat[55:48]); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        busy           = 1'b0;
        host_oe        = 1'b0;
        host_data      = 8'h00;
        epp_if.EppAstb = 1'b1;
        epp_if.EppDstb = 1'b1;
        epp_if.EppWR   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset;
        test_write_latency;
        test_auto_inc;
        test_cmd;
        test_cmd_busy;
        test_read;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
